// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (double dabble).
// One operand bit is processed per clock. valid/ready handshake on input and
// output. Values >= 10^DIGITS are saturated to all nines and flagged.
// Optional feature: define LEADING_ZERO_BLANK_EN to build the leading-zero
// blanking mask on blank_o; otherwise blank_o is tied to zero.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [WIDTH-1:0]      number_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [4*DIGITS-1:0]   digits_o,
    output logic                  overflow_o,
    output logic [DIGITS-1:0]     blank_o
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Add 3 to every digit that is 5 or more, so the following shift
    // carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        logic [3:0]       dig;
        res = '0;
        for (int k = 0; k < DIGITS; k++) begin
            dig = bcd[4*k +: 4];
            if (dig >= 4'd5) begin
                res[4*k +: 4] = dig + 4'd3;
            end else begin
                res[4*k +: 4] = dig;
            end
        end
        return res;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Mark digits k >= 1 that are zero with only zeros above them; the units
    // digit is never blanked so a zero value still shows one "0".
    function automatic logic [DIGITS-1:0] lead_zero_mask(input logic [BCD_W-1:0] bcd);
        logic [DIGITS-1:0] mask;
        logic              above_zero;
        mask       = '0;
        above_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (above_zero && (bcd[4*k +: 4] == 4'd0)) begin
                mask[k] = 1'b1;
            end else begin
                mask[k]    = 1'b0;
                above_zero = 1'b0;
            end
        end
        return mask;
    endfunction
`endif

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   shift_q,  shift_d;
    logic [BCD_W-1:0]   bcd_q,    bcd_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               sticky_q, sticky_d;
    logic [BCD_W-1:0]   digits_q, digits_d;
    logic               ovf_q,    ovf_d;
`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0]  blank_q,  blank_d;
`endif

    logic [BCD_W-1:0]   bcd_adj_s;
    logic [BCD_W-1:0]   bcd_step_s;
    logic [WIDTH-1:0]   shift_step_s;
    logic               carry_s;
    logic               ovf_final_s;

    // One double-dabble step: adjust digits, then shift {bcd, shift} left.
    always_comb begin
        bcd_adj_s    = dd_adjust(bcd_q);
        carry_s      = bcd_adj_s[BCD_W-1];
        bcd_step_s   = {bcd_adj_s[BCD_W-2:0], shift_q[WIDTH-1]};
        shift_step_s = {shift_q[WIDTH-2:0], 1'b0};
        ovf_final_s  = sticky_q | carry_s;
    end

    // Next-state and datapath control for IDLE / SHIFT / DONE.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        digits_d = digits_q;
        ovf_d    = ovf_q;
`ifdef LEADING_ZERO_BLANK_EN
        blank_d  = blank_q;
`endif
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    shift_d  = number_i;
                    bcd_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = CNT_W'(WIDTH);
                    state_d  = SHIFT;
                end else begin
                    state_d  = IDLE;
                end
            end
            SHIFT: begin
                bcd_d    = bcd_step_s;
                shift_d  = shift_step_s;
                cnt_d    = cnt_q - CNT_W'(1);
                sticky_d = ovf_final_s;
                if (cnt_q == CNT_W'(1)) begin
                    // Last shift: capture the result into the output registers.
                    state_d  = DONE;
                    ovf_d    = ovf_final_s;
                    digits_d = ovf_final_s ? ALL_NINES : bcd_step_s;
`ifdef LEADING_ZERO_BLANK_EN
                    blank_d  = ovf_final_s ? '0 : lead_zero_mask(bcd_step_s);
`endif
                end else begin
                    state_d  = SHIFT;
                end
            end
            DONE: begin
                if (ready_i) begin
                    if (valid_i) begin
                        shift_d  = number_i;
                        bcd_d    = '0;
                        sticky_d = 1'b0;
                        cnt_d    = CNT_W'(WIDTH);
                        state_d  = SHIFT;
                    end else begin
                        state_d  = IDLE;
                    end
                end else begin
                    state_d  = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            digits_q <= '0;
            ovf_q    <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            blank_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
`ifdef LEADING_ZERO_BLANK_EN
            blank_q  <= blank_d;
`endif
        end
    end

    // Input-side ready: only DONE passes ready_i straight through.
    always_comb begin
        ready_o = 1'b0;
        case (state_q)
            IDLE:    ready_o = 1'b1;
            SHIFT:   ready_o = 1'b0;
            DONE:    ready_o = ready_i;
            default: ready_o = 1'b0;
        endcase
    end

    assign valid_o    = (state_q == DONE);
    assign digits_o   = digits_q;
    assign overflow_o = ovf_q;
`ifdef LEADING_ZERO_BLANK_EN
    assign blank_o    = blank_q;
`else
    assign blank_o    = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed testbench for bin_to_bcd_seq: default 14-bit/4-digit instance and
// a 20-bit/6-digit instance. Blank expectations follow LEADING_ZERO_BLANK_EN.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst;

    // 14-bit / 4-digit instance
    logic        valid_i;
    logic        ready_o;
    logic [13:0] number_i;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] digits_o;
    logic        overflow_o;
    logic [3:0]  blank_o;

    // 20-bit / 6-digit instance
    logic        valid2_i;
    logic        ready2_o;
    logic [19:0] number2_i;
    logic        valid2_o;
    logic        ready2_i;
    logic [23:0] digits2_o;
    logic        overflow2_o;
    logic [5:0]  blank2_o;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_blank_zero;
    logic [3:0] exp_blank_42;
    logic [3:0] exp_blank_77;

    bin_to_bcd_seq #(.WIDTH(14), .DIGITS(4)) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .number_i   (number_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .digits_o   (digits_o),
        .overflow_o (overflow_o),
        .blank_o    (blank_o)
    );

    bin_to_bcd_seq #(.WIDTH(20), .DIGITS(6)) u_dut_wide (
        .clk_i      (clk),
        .rst_i      (rst),
        .valid_i    (valid2_i),
        .ready_o    (ready2_o),
        .number_i   (number2_i),
        .valid_o    (valid2_o),
        .ready_i    (ready2_i),
        .digits_o   (digits2_o),
        .overflow_o (overflow2_o),
        .blank_o    (blank2_o)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Present n on the 14-bit instance and hold valid_i through one accept edge.
    task automatic accept1(input logic [13:0] n);
        int guard;
        guard = 0;
        while (!ready_o && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("accept_ready", 64'(ready_o), 64'd1);
        valid_i  = 1'b1;
        number_i = n;
        @(posedge clk); #1;
        valid_i  = 1'b0;
    endtask

    // Count edges until valid_o of the 14-bit instance is seen (bounded).
    task automatic wait_res1(output int lat);
        lat = 0;
        while (!valid_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("valid_seen", 64'(valid_o), 64'd1);
    endtask

    // Convert n on the 20-bit instance and report the latency.
    task automatic run2(input logic [19:0] n, output int lat);
        valid2_i  = 1'b1;
        number2_i = n;
        @(posedge clk); #1;
        valid2_i  = 1'b0;
        lat = 0;
        while (!valid2_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("valid2_seen", 64'(valid2_o), 64'd1);
    endtask

    // Directed stimulus sequence.
    initial begin
        int lat;
        int seen;
`ifdef LEADING_ZERO_BLANK_EN
        exp_blank_zero = 4'b1110;
        exp_blank_42   = 4'b1100;
        exp_blank_77   = 4'b1100;
`else
        exp_blank_zero = 4'b0000;
        exp_blank_42   = 4'b0000;
        exp_blank_77   = 4'b0000;
`endif
        rst       = 1'b1;
        valid_i   = 1'b0;
        number_i  = 14'd0;
        ready_i   = 1'b1;
        valid2_i  = 1'b0;
        number2_i = 20'd0;
        ready2_i  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",    64'(ready_o),    64'd1);
        check("rst_valid",    64'(valid_o),    64'd0);
        check("rst_digits",   64'(digits_o),   64'd0);
        check("rst_overflow", 64'(overflow_o), 64'd0);
        check("rst_blank",    64'(blank_o),    64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1234: latency and value
        accept1(14'd1234);
        wait_res1(lat);
        check("lat_1234",    64'(lat),        64'd14);
        check("dig_1234",    64'(digits_o),   64'h1234);
        check("ovf_1234",    64'(overflow_o), 64'd0);
        check("blank_1234",  64'(blank_o),    64'd0);
        @(posedge clk); #1;
        check("idle_after_1234", 64'(valid_o), 64'd0);
        check("ready_after_1234", 64'(ready_o), 64'd1);

        // 0 then 9999 back-to-back, valid_i held
        valid_i  = 1'b1;
        number_i = 14'd0;
        @(posedge clk); #1;
        number_i = 14'd9999;
        wait_res1(lat);
        check("lat_zero",    64'(lat),        64'd14);
        check("dig_zero",    64'(digits_o),   64'h0000);
        check("blank_zero",  64'(blank_o),    64'(exp_blank_zero));
        check("ready_done",  64'(ready_o),    64'd1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        check("b2b_in_shift", 64'(valid_o),   64'd0);
        wait_res1(lat);
        check("lat_b2b",     64'(lat + 1),    64'd15);
        check("dig_9999",    64'(digits_o),   64'h9999);
        check("ovf_9999",    64'(overflow_o), 64'd0);
        check("blank_9999",  64'(blank_o),    64'd0);
        @(posedge clk); #1;

        // overflow saturation
        accept1(14'd10000);
        wait_res1(lat);
        check("ovf_10000",   64'(overflow_o), 64'd1);
        check("dig_10000",   64'(digits_o),   64'h9999);
        check("blank_10000", 64'(blank_o),    64'd0);
        @(posedge clk); #1;
        accept1(14'd16383);
        wait_res1(lat);
        check("ovf_16383",   64'(overflow_o), 64'd1);
        check("dig_16383",   64'(digits_o),   64'h9999);
        check("blank_16383", 64'(blank_o),    64'd0);
        @(posedge clk); #1;
        accept1(14'd42);
        wait_res1(lat);
        check("ovf_42",      64'(overflow_o), 64'd0);
        check("dig_42",      64'(digits_o),   64'h0042);
        check("blank_42",    64'(blank_o),    64'(exp_blank_42));
        @(posedge clk); #1;

        // backpressure with ignored valid_i pulses
        ready_i = 1'b0;
        accept1(14'd507);
        wait_res1(lat);
        for (int i = 0; i < 20; i++) begin
            check("bp_digits", 64'(digits_o),   64'h0507);
            check("bp_valid",  64'(valid_o),    64'd1);
            check("bp_ready",  64'(ready_o),    64'd0);
            check("bp_ovf",    64'(overflow_o), 64'd0);
            valid_i  = i[0];
            number_i = 14'd99;
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        #1;
        check("bp_ready_release", 64'(ready_o), 64'd1);
        @(posedge clk); #1;
        check("bp_idle_valid",  64'(valid_o),  64'd0);
        check("bp_idle_ready",  64'(ready_o),  64'd1);
        check("bp_hold_digits", 64'(digits_o), 64'h0507);

        // reset in the middle of SHIFT
        accept1(14'd321);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_valid",  64'(valid_o),  64'd0);
        check("mid_rst_digits", 64'(digits_o), 64'd0);
        check("mid_rst_ready",  64'(ready_o),  64'd1);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (valid_o) seen++;
        end
        check("mid_rst_no_result", 64'(seen), 64'd0);
        accept1(14'd77);
        wait_res1(lat);
        check("dig_77",   64'(digits_o),   64'h0077);
        check("ovf_77",   64'(overflow_o), 64'd0);
        check("blank_77", 64'(blank_o),    64'(exp_blank_77));
        @(posedge clk); #1;

        // 20-bit / 6-digit instance
        run2(20'd999999, lat);
        check("w_lat_999999", 64'(lat),         64'd20);
        check("w_dig_999999", 64'(digits2_o),   64'h999999);
        check("w_ovf_999999", 64'(overflow2_o), 64'd0);
        @(posedge clk); #1;
        run2(20'd1048575, lat);
        check("w_lat_max",    64'(lat),         64'd20);
        check("w_dig_max",    64'(digits2_o),   64'h999999);
        check("w_ovf_max",    64'(overflow2_o), 64'd1);
        check("w_blank_max",  64'(blank2_o),    64'd0);
        @(posedge clk); #1;
        check("w_idle_ready", 64'(ready2_o),    64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
